// File: rtl/stdp_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : stdp_update_sched
// Description : Detects STDP pre/post pairing events, queues one pending
//               weight update per synapse and issues them round-robin to a
//               shared weight-update unit over a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module stdp_update_sched #(
    parameter int NUM_PRE = 4,
    parameter int TW      = 4,
    parameter int WINDOW  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_PRE-1:0]         pre_spike,
    input  logic                       post_spike,
    output logic                       upd_req,
    input  logic                       upd_ack,
    output logic [$clog2(NUM_PRE)-1:0] upd_idx,
    output logic [TW-1:0]              upd_dt,
    output logic                       upd_ltp,
    output logic                       busy,
    output logic [NUM_PRE-1:0]         pend,
    output logic [7:0]                 ovf_cnt
);

    localparam int            IDXW    = $clog2(NUM_PRE);
    localparam logic [TW-1:0] TMAX    = '1;
    localparam logic [TW-1:0] WIN     = TW'(WINDOW);
    localparam logic [0:0]    ST_IDLE = 1'b0;
    localparam logic [0:0]    ST_REQ  = 1'b1;

    logic [TW-1:0]      pre_tmr_q  [NUM_PRE];
    logic [TW-1:0]      post_tmr_q;
    logic [TW-1:0]      slot_dt_q  [NUM_PRE];
    logic [NUM_PRE-1:0] slot_ltp_q;
    logic [NUM_PRE-1:0] pend_q, pend_d;
    logic [0:0]         state_q, state_d;
    logic [IDXW-1:0]    rr_ptr_q, rr_ptr_d;
    logic               req_q, req_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [TW-1:0]      dt_q, dt_d;
    logic               ltp_q, ltp_d;
    logic [7:0]         ovf_q, ovf_d;

    logic [NUM_PRE-1:0] cap, cap_ltp, cap_ltd, grant_oh, ovf_hits;
    logic [TW-1:0]      cap_dt [NUM_PRE];
    logic               grant_vld;
    logic [IDXW-1:0]    grant_idx, cand;
    logic [15:0]        ovf_sum;

    // Timers saturate at TMAX so a long-quiet input never looks recent.
    always_ff @(posedge clk) begin
        if (!rst_n)
            post_tmr_q <= TMAX;
        else if (post_spike)
            post_tmr_q <= TW'(1);
        else if (post_tmr_q != TMAX)
            post_tmr_q <= post_tmr_q + TW'(1);
    end

    generate
        for (genvar i = 0; i < NUM_PRE; i++) begin : g_syn
            always_ff @(posedge clk) begin
                if (!rst_n)
                    pre_tmr_q[i] <= TMAX;
                else if (pre_spike[i])
                    pre_tmr_q[i] <= TW'(1);
                else if (pre_tmr_q[i] != TMAX)
                    pre_tmr_q[i] <= pre_tmr_q[i] + TW'(1);
            end

            // Coincident pre and post counts as LTP with dt=0, never LTD.
            assign cap_ltp[i] = post_spike & (pre_spike[i] | (pre_tmr_q[i] < WIN));
            assign cap_ltd[i] = pre_spike[i] & ~post_spike & (post_tmr_q < WIN);
            assign cap[i]     = cap_ltp[i] | cap_ltd[i];
            assign cap_dt[i]  = cap_ltd[i]   ? post_tmr_q :
                                pre_spike[i] ? '0 : pre_tmr_q[i];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    slot_dt_q[i]  <= '0;
                    slot_ltp_q[i] <= 1'b0;
                end else if (cap[i]) begin
                    slot_dt_q[i]  <= cap_dt[i];
                    slot_ltp_q[i] <= cap_ltp[i];
                end
            end
        end
    endgenerate

    // Descending scan so the candidate closest to rr_ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_PRE - 1; k >= 0; k--) begin
            cand = rr_ptr_q + IDXW'(k);
            if (pend_q[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (state_q != ST_IDLE)
            grant_vld = 1'b0;
    end

    assign grant_oh = grant_vld ? (NUM_PRE'(1) << grant_idx) : '0;
    // A capture landing on the slot being granted is a refill, not an overwrite.
    assign ovf_hits = cap & pend_q & ~grant_oh;
    assign pend_d   = (pend_q & ~grant_oh) | cap;

    always_comb begin
        ovf_sum = 16'(ovf_q);
        for (int k = 0; k < NUM_PRE; k++)
            ovf_sum = ovf_sum + 16'(ovf_hits[k]);
        ovf_d = (ovf_sum > 16'd255) ? 8'hFF : ovf_sum[7:0];
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        req_d    = req_q;
        idx_d    = idx_q;
        dt_d     = dt_q;
        ltp_d    = ltp_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    idx_d   = grant_idx;
                    dt_d    = slot_dt_q[grant_idx];
                    ltp_d   = slot_ltp_q[grant_idx];
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (upd_ack) begin
                    req_d    = 1'b0;
                    rr_ptr_d = idx_q + IDXW'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            req_q    <= 1'b0;
            idx_q    <= '0;
            dt_q     <= '0;
            ltp_q    <= 1'b0;
            pend_q   <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            req_q    <= req_d;
            idx_q    <= idx_d;
            dt_q     <= dt_d;
            ltp_q    <= ltp_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
        end
    end

    assign upd_req = req_q;
    assign busy    = req_q;
    assign upd_idx = idx_q;
    assign upd_dt  = dt_q;
    assign upd_ltp = ltp_q;
    assign pend    = pend_q;
    assign ovf_cnt = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stdp_update_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_stdp_update_sched
// Description : Directed self-checking bench for stdp_update_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stdp_update_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pre_spike;
    logic       post_spike;
    logic       upd_req;
    logic       upd_ack;
    logic [1:0] upd_idx;
    logic [3:0] upd_dt;
    logic       upd_ltp;
    logic       busy;
    logic [3:0] pend;
    logic [7:0] ovf_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    stdp_update_sched #(.NUM_PRE(4), .TW(4), .WINDOW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pre_spike  (pre_spike),
        .post_spike (post_spike),
        .upd_req    (upd_req),
        .upd_ack    (upd_ack),
        .upd_idx    (upd_idx),
        .upd_dt     (upd_dt),
        .upd_ltp    (upd_ltp),
        .busy       (busy),
        .pend       (pend),
        .ovf_cnt    (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic [1:0] idx,
                           input logic [3:0] dt, input logic ltp);
        chk({tag, ".req"},  32'(upd_req), 32'd1);
        chk({tag, ".busy"}, 32'(busy),    32'd1);
        chk({tag, ".idx"},  32'(upd_idx), 32'(idx));
        chk({tag, ".dt"},   32'(upd_dt),  32'(dt));
        chk({tag, ".ltp"},  32'(upd_ltp), 32'(ltp));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pre_spike  = '0;
        post_spike = 1'b0;
        upd_ack    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] pe;

        // 1: reset state and quiet idle
        do_reset();
        chk("rst.req",  32'(upd_req), 0);
        chk("rst.busy", 32'(busy),    0);
        chk("rst.idx",  32'(upd_idx), 0);
        chk("rst.dt",   32'(upd_dt),  0);
        chk("rst.ltp",  32'(upd_ltp), 0);
        chk("rst.pend", 32'(pend),    0);
        chk("rst.ovf",  32'(ovf_cnt), 0);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("idle.req",  32'(upd_req), 0);
            chk("idle.pend", 32'(pend),    0);
            chk("idle.ovf",  32'(ovf_cnt), 0);
        end

        // 2: pre[2] then post 3 edges later -> LTP dt=3
        pre_spike = 4'b0100; tick();
        pre_spike = 4'b0000; tick(); tick();
        post_spike = 1'b1; tick();
        post_spike = 1'b0;
        chk("t2.pend", 32'(pend), 32'b0100);
        chk("t2.noreq", 32'(upd_req), 0);
        tick();
        chk_req("t2.grant", 2'd2, 4'd3, 1'b1);
        chk("t2.pend_clr", 32'(pend), 0);
        tick();
        chk_req("t2.hold", 2'd2, 4'd3, 1'b1);
        upd_ack = 1'b1; tick(); upd_ack = 1'b0;
        chk("t2.ack.req",  32'(upd_req), 0);
        chk("t2.ack.busy", 32'(busy),    0);

        // 3: post then pre[1] 5 edges later -> LTD dt=5; dt=8 is outside window
        do_reset();
        post_spike = 1'b1; tick(); post_spike = 1'b0;
        repeat (4) tick();
        pre_spike = 4'b0010; tick(); pre_spike = 4'b0000;
        chk("t3.pend", 32'(pend), 32'b0010);
        tick();
        chk_req("t3.grant", 2'd1, 4'd5, 1'b0);
        upd_ack = 1'b1; tick(); upd_ack = 1'b0;
        chk("t3.ack.req", 32'(upd_req), 0);
        repeat (20) tick();
        post_spike = 1'b1; tick(); post_spike = 1'b0;
        repeat (7) tick();
        pre_spike = 4'b1000; tick(); pre_spike = 4'b0000;
        chk("t3.win.pend", 32'(pend), 0);
        tick();
        chk("t3.win.req", 32'(upd_req), 0);

        // 4: all four synapses fire, post 2 edges later -> four grants in order
        do_reset();
        pre_spike = 4'b1111; tick(); pre_spike = 4'b0000;
        tick();
        post_spike = 1'b1; tick(); post_spike = 1'b0;
        chk("t4.pend", 32'(pend), 32'b1111);
        for (int k = 0; k < 4; k++) begin
            tick();
            pe = 4'b1111 << (k + 1);
            chk_req("t4.grant", 2'(k), 4'd2, 1'b1);
            chk("t4.pend_dec", 32'(pend), 32'(pe));
            tick(); tick();
            chk_req("t4.hold", 2'(k), 4'd2, 1'b1);
            upd_ack = 1'b1; tick(); upd_ack = 1'b0;
            chk("t4.ack.req", 32'(upd_req), 0);
        end
        tick();
        chk("t4.done.req", 32'(upd_req), 0);

        // 5: coincident pre[0]/post -> one LTP dt=0, no LTD
        do_reset();
        pre_spike = 4'b0001; post_spike = 1'b1; tick();
        pre_spike = 4'b0000; post_spike = 1'b0;
        chk("t5.pend", 32'(pend), 32'b0001);
        tick();
        chk_req("t5.grant", 2'd0, 4'd0, 1'b1);
        upd_ack = 1'b1; tick(); upd_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("t5.noltd.req",  32'(upd_req), 0);
            chk("t5.noltd.pend", 32'(pend),    0);
        end

        // 7: window edge dt=WINDOW-1 is still accepted
        do_reset();
        pre_spike = 4'b0001; tick(); pre_spike = 4'b0000;
        repeat (6) tick();
        post_spike = 1'b1; tick(); post_spike = 1'b0;
        tick();
        chk_req("t7.grant", 2'd0, 4'd7, 1'b1);

        // 6: overwrite while synapse 0 is held un-acked, then reset in REQ
        do_reset();
        pre_spike = 4'b0001; post_spike = 1'b1; tick();
        pre_spike = 4'b0000; post_spike = 1'b0;
        tick();
        chk_req("t6.grant0", 2'd0, 4'd0, 1'b1);
        repeat (16) tick();
        pre_spike = 4'b0010; tick(); pre_spike = 4'b0000;
        chk("t6.stale.pend", 32'(pend), 0);
        tick();
        post_spike = 1'b1; tick(); post_spike = 1'b0;
        chk("t6.ltp.pend", 32'(pend),    32'b0010);
        chk("t6.ltp.ovf",  32'(ovf_cnt), 0);
        pre_spike = 4'b0010; tick(); pre_spike = 4'b0000;
        chk("t6.ovw.pend", 32'(pend),    32'b0010);
        chk("t6.ovw.ovf",  32'(ovf_cnt), 1);
        chk_req("t6.inflight", 2'd0, 4'd0, 1'b1);
        upd_ack = 1'b1; tick(); upd_ack = 1'b0;
        chk("t6.ack.req", 32'(upd_req), 0);
        tick();
        chk_req("t6.grant1", 2'd1, 4'd1, 1'b0);
        pre_spike = 4'b0100; tick(); pre_spike = 4'b0000;
        chk("t6.ltd2.pend", 32'(pend), 32'b0100);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("t6.rst.req",  32'(upd_req), 0);
        chk("t6.rst.busy", 32'(busy),    0);
        chk("t6.rst.pend", 32'(pend),    0);
        chk("t6.rst.ovf",  32'(ovf_cnt), 0);
        tick();
        chk("t6.post_rst.req", 32'(upd_req), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stdp_update_sched.md
Name: stdp_update_sched

Overview:
Controller that detects STDP pairing events between NUM_PRE presynaptic inputs and one postsynaptic input. It queues one pending weight update per synapse and issues those updates, one at a time, to a single shared weight-update unit through a valid/ack handshake. A round-robin arbiter shares the update unit fairly among synapses. The block sits between the spike sources and the weight datapath and owns all spike-timing bookkeeping.

Parameters:
NUM_PRE, 4, number of presynaptic inputs/synapses (power of 2, >=2)
TW, 4, spike timer and dt width in bits
WINDOW, 8, pairing window in cycles; legal range 1..(2^TW-1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
pre_spike  in  NUM_PRE  presynaptic spike pulses, one bit per synapse
post_spike  in  1  postsynaptic spike pulse
upd_req  out  1  update request valid to the shared weight unit
upd_ack  in  1  weight unit accepts the current request
upd_idx  out  log2(NUM_PRE)  synapse index of the current request
upd_dt  out  TW  spike time difference of the current request
upd_ltp  out  1  1 = potentiate (pre before post), 0 = depress (post before pre)
busy  out  1  high while a request is outstanding
pend  out  NUM_PRE  per-synapse pending-update flags
ovf_cnt  out  8  count of pending updates overwritten before service, saturating

Behaviour:
- Reset, synchronous on the clk edge with rst_n=0:
  - All timers set to 2^TW-1 (stale).
  - upd_req, upd_idx, upd_dt, upd_ltp, busy, pend and ovf_cnt all set to 0.
  - rr_ptr set to 0; FSM set to IDLE.
- Reset mid-request drops the request: upd_req is 0 after that edge. No ack is expected afterwards.
- Timers: one per pre input plus one post timer, each TW bits.
  - A spike sampled at an edge loads the timer with 1.
  - Otherwise the timer increments and saturates at 2^TW-1; it never wraps.
  - A timer value n therefore means the last spike was n edges ago.
- Event capture, using timer values from before the edge:
  - post_spike=1 and pre_spike[i]=1 in the same cycle: LTP, dt=0. No LTD is generated for synapse i.
  - post_spike=1, pre_spike[i]=0, pre_timer[i] < WINDOW: LTP, dt=pre_timer[i].
  - pre_spike[i]=1, post_spike=0, post_timer < WINDOW: LTD, dt=post_timer.
  - A captured event writes slot i {dt, ltp} and sets pend[i] at that edge.
  - Capture into a slot whose pend[i] is already 1 overwrites the slot (newest event wins) and increments ovf_cnt by 1, saturating at 255.
- FSM, two states:
  - IDLE: if pend is nonzero, select the first i with pend[i]=1, searching from rr_ptr upward and wrapping modulo NUM_PRE.
    - At that edge: latch upd_idx, upd_dt and upd_ltp from slot i; clear pend[i]; set upd_req=1 and busy=1; go to REQ.
    - If an event is captured for i at that same edge, the capture wins: pend[i] stays 1 with the new data, and ovf_cnt does not increment.
  - REQ: upd_idx, upd_dt and upd_ltp are held stable until upd_ack=1 is sampled.
    - On ack: upd_req=0, busy=0, rr_ptr <= upd_idx+1 modulo NUM_PRE, go to IDLE.
    - Events captured during REQ only update the pend slots; they never alter the in-flight request.
- Latency and throughput:
  - A capture at edge k gives upd_req=1 after edge k+1, provided the FSM is IDLE.
  - At most one request every 2 cycles: upd_req is low for at least one cycle between requests.
- upd_ack is ignored in IDLE.
- upd_req never drops without an ack, except on reset.

Test Plan:
1. Reset, then 20 idle cycles with no spikes -> upd_req=0, pend=0, ovf_cnt=0 throughout.
2. pre_spike[2] at edge 0, post_spike at edge 3 -> pend[2]=1 after edge 3; upd_req=1 after edge 4 with upd_idx=2, upd_dt=3, upd_ltp=1; ack at edge 6 -> upd_req=0 after edge 6.
3. post_spike at edge 0 and pre_spike[1] at edge 5 -> LTD request with upd_idx=1, upd_dt=5, upd_ltp=0. Then post_spike at edge 20 and pre_spike[3] at edge 28 (dt=8, not < WINDOW) -> no request.
4. pre_spike=4'b1111 at edge 0, post_spike at edge 2, ack returned 3 cycles after each request -> four LTP requests with dt=2 in idx order 0,1,2,3; outputs stable while waiting; pend decrements one bit per grant.
5. pre_spike[0] and post_spike in the same cycle -> exactly one request: upd_idx=0, upd_dt=0, upd_ltp=1; no LTD request follows.
6. pre_spike[1] at edge 0, post_spike at edge 2, pre_spike[1] at edge 3, all while a request for synapse 0 is held un-acked:
   - The LTP on synapse 1 (dt=2) is overwritten by an LTD (dt=1), and ovf_cnt becomes 1; after the ack, the synapse 1 request is upd_dt=1, upd_ltp=0.
   - rst_n=0 asserted during REQ -> upd_req=0 and pend=0 after that edge.
